adc0804_responder: RTL and testbench

Synthesizable stand-in for the 8-bit parallel ADC that our ADC readout logic drives. It sits on the ADC side of the Start/D interface.
- Watches the Start pulse.
- Samples an 8-bit value, taken either from switches or from an internal ramp.
- Waits a fixed conversion time, then presents the result on D and flags completion.

It lets the readout and 7-segment display path run on the board or in simulation without a real converter attached.

---
 rtl/adc0804_responder.sv | 116 +++++++++++
 tb/tb_adc0804_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/adc0804_responder.sv
// Stand-in for an 8-bit parallel ADC on the Start/D handshake: qualifies the
// Start pulse width, samples ain or an internal ramp, and presents D after CONV_CYCLES.
module adc0804_responder #(
  parameter int CONV_CYCLES = 64,
  parameter int MIN_START   = 4,
  parameter int RAMP_STEP   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic [7:0] ain,
  input  logic       mode,
  output logic [7:0] D,
  output logic       INTR_n,
  output logic       busy,
  output logic       start_err
);

  localparam int CW = $clog2(CONV_CYCLES);
  localparam int WW = $clog2(MIN_START + 1);

  typedef enum logic [1:0] {IDLE, ARM, CONV, DONE} state_t;

  state_t          state_q;
  logic            start_q;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      ramp_q;
  logic [7:0]      d_q;
  logic            intr_n_q, busy_q, start_err_q;
  logic [7:0]      sample_q;
  logic            smode_q;
  logic            rise, fall, accept;

  assign rise   = Start & ~start_q;
  assign fall   = ~Start & start_q;
  assign accept = (state_q == ARM) && fall && (wcnt_q >= WW'(MIN_START));

  // The rise cycle is itself the first high cycle, so a k-cycle pulse counts k.
  always_comb begin
    wcnt_d = wcnt_q;
    if (rise)
      wcnt_d = WW'(1);
    else if (Start && (wcnt_q < WW'(MIN_START)))
      wcnt_d = wcnt_q + WW'(1);
  end

  // Captured sample and its source; no reset needed, only read after a capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      sample_q <= mode ? ramp_q : ain;
      smode_q  <= mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      wcnt_q      <= '0;
      cnt_q       <= '0;
      ramp_q      <= 8'd0;
      d_q         <= 8'd0;
      intr_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      start_q     <= Start;
      wcnt_q      <= wcnt_d;
      start_err_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (rise) begin
            state_q  <= ARM;
            intr_n_q <= 1'b1;
          end
        end
        ARM: begin
          if (fall) begin
            if (accept) begin
              state_q <= CONV;
              cnt_q   <= CW'(CONV_CYCLES - 1);
              busy_q  <= 1'b1;
            end else begin
              state_q     <= IDLE;
              start_err_q <= 1'b1;
            end
          end
        end
        CONV: begin
          // A new request wins over a completion landing on the same edge.
          if (rise) begin
            state_q <= ARM;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q  <= DONE;
            d_q      <= sample_q;
            intr_n_q <= 1'b0;
            busy_q   <= 1'b0;
            if (smode_q)
              ramp_q <= ramp_q + 8'(RAMP_STEP);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign D         = d_q;
  assign INTR_n    = intr_n_q;
  assign busy      = busy_q;
  assign start_err = start_err_q;

endmodule

// File: tb/tb_adc0804_responder.sv
// Directed bench for adc0804_responder: reset, nominal conversion, short-pulse
// rejection, abort on re-request, reset mid-conversion and ramp wrap.
module tb_adc0804_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start;
  logic [7:0] ain;
  logic       mode;
  logic [7:0] D;
  logic       INTR_n, busy, start_err;

  int errors = 0;
  int checks = 0;

  adc0804_responder #(.CONV_CYCLES(64), .MIN_START(4), .RAMP_STEP(1)) dut (
    .clk(clk), .rst(rst), .Start(Start), .ain(ain), .mode(mode),
    .D(D), .INTR_n(INTR_n), .busy(busy), .start_err(start_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start high for w cycles, then run to edge N+64 checking busy along the way.
  task automatic conv(input int w);
    Start = 1'b1;
    repeat (w) tick();
    Start = 1'b0;
    tick();
    check("busy_at_N", busy, 1);
    repeat (63) tick();
    check("busy_at_N63", busy, 1);
    tick();
    check("busy_at_N64", busy, 0);
    check("intr_at_N64", INTR_n, 0);
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; ain = 8'd0; mode = 1'b0;
    tick();
    check("rst_D", D, 8'h00);
    check("rst_INTR", INTR_n, 1);
    check("rst_busy", busy, 0);
    check("rst_err", start_err, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Nominal conversion, ain=173, 10-cycle Start
    ain = 8'd173;
    conv(10);
    check("nom_D", D, 173);
    repeat (5) tick();
    check("nom_hold_D", D, 173);
    check("nom_hold_INTR", INTR_n, 0);

    // Short 2-cycle pulse: INTR_n clears at the rise, then rejected at the fall
    Start = 1'b1;
    tick();
    check("rise_INTR", INTR_n, 1);
    check("rise_D", D, 173);
    tick();
    Start = 1'b0;
    tick();
    check("short_err", start_err, 1);
    check("short_busy", busy, 0);
    check("short_D", D, 173);
    tick();
    check("short_err_clr", start_err, 0);
    repeat (70) tick();
    check("short_noconv_D", D, 173);
    check("short_noconv_INTR", INTR_n, 1);

    // 3-cycle pulse is also below the minimum
    Start = 1'b1;
    repeat (3) tick();
    Start = 1'b0;
    tick();
    check("w3_err", start_err, 1);
    check("w3_busy", busy, 0);

    // Abort: 5-cycle request with ain=77, re-request 30 cycles after N
    ain = 8'd77;
    Start = 1'b1;
    repeat (5) tick();
    Start = 1'b0;
    tick();
    check("w5_busy", busy, 1);
    repeat (30) tick();
    Start = 1'b1;
    ain = 8'd42;
    tick();
    check("abort_busy", busy, 0);
    check("abort_D", D, 173);
    check("abort_INTR", INTR_n, 1);
    repeat (9) tick();
    Start = 1'b0;
    tick();
    check("abort2_busy", busy, 1);
    ain = 8'd11;
    mode = 1'b1;
    repeat (30) tick();
    check("abort_mid_D", D, 173);
    repeat (33) tick();
    check("abort2_N63_INTR", INTR_n, 1);
    tick();
    check("abort2_D", D, 42);
    check("abort2_INTR", INTR_n, 0);
    check("abort2_busy_end", busy, 0);
    mode = 1'b0;
    repeat (3) tick();

    // Reset at cycle 20 of a conversion discards it
    ain = 8'd55;
    Start = 1'b1;
    repeat (10) tick();
    Start = 1'b0;
    tick();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("midrst_D", D, 0);
    check("midrst_INTR", INTR_n, 1);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    repeat (60) tick();
    check("midrst_noresult_D", D, 0);
    check("midrst_noresult_INTR", INTR_n, 1);
    check("midrst_noresult_busy", busy, 0);

    // Ramp: 254 conversions from 0, first with a long-held Start
    mode = 1'b1;
    ain = 8'd200;
    for (int i = 0; i < 254; i++) begin
      conv((i == 0) ? 100 : 5);
      if (i < 3) check("ramp_seq", D, i);
      tick();
    end
    conv(5);
    check("ramp_254", D, 254);
    tick();
    conv(5);
    check("ramp_255", D, 255);
    tick();
    conv(5);
    check("ramp_wrap_0", D, 0);
    tick();
    conv(5);
    check("ramp_after_wrap", D, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
